// File: rtl/serial_add_controller.sv
// ---------------------------------------------------------------------------
// serial_add_controller
//   Bit-serial adder sequencer. Drives one shared, external 1-bit full adder
//   to add two WIDTH-bit operands one bit per clock, LSB first. Operands and
//   the initial carry are latched on the accept edge. Sum, carry-out and
//   signed overflow come back together with a one-cycle done pulse.
//
//   Ports
//     clk, rst          clock (rising edge), asynchronous active-high reset
//     start             request; only looked at while idle
//     a_in, b_in        WIDTH-bit operands, captured on the accept edge
//     cin_in            initial carry, captured on the accept edge
//     fa_a, fa_b        operand bits to the full adder
//     fa_cin            carry bit to the full adder
//     fa_sum, fa_cout   combinational results from the full adder
//     busy              high while an add is in flight (RUN and DONE)
//     done              one-cycle pulse, results valid
//     sum_out           WIDTH-bit sum, held until the next add finishes
//     cout_out          final carry-out, held
//     ovf_out           signed overflow, held
// ---------------------------------------------------------------------------
module serial_add_controller #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out,
   output logic             ovf_out
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             carry;
   logic [IDX_W-1:0] idx;

   // Signed overflow: carry into the MSB differs from carry out of it.
   function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
      return c_into_msb ^ c_out_msb;
   endfunction

   // Operand registers shift right each RUN cycle, so bit idx is always at
   // position 0; result bits enter at the MSB and end up in place after
   // WIDTH shifts.
   logic [WIDTH-1:0] res_next;
   assign res_next = {fa_sum, res_sr[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         carry    <= 1'b0;
         idx      <= '0;
         done     <= 1'b0;
         sum_out  <= '0;
         cout_out <= 1'b0;
         ovf_out  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr   <= a_in;
                  b_sr   <= b_in;
                  res_sr <= '0;
                  carry  <= cin_in;
                  idx    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next;
               carry  <= fa_cout;
               idx    <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  sum_out  <= res_next;
                  cout_out <= fa_cout;
                  ovf_out  <= signed_ovf(carry, fa_cout);
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Adder inputs come only from registered state; zero outside RUN.
   assign busy   = (state != IDLE);
   assign fa_a   = (state == RUN) & a_sr[0];
   assign fa_b   = (state == RUN) & b_sr[0];
   assign fa_cin = (state == RUN) & carry;

endmodule
